// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: steps one dense layer over a shared neuron MAC datapath.
// Each row is fetched, the memory read latency is waited out, and the 32-bit result
// is captured and requantised (optional ReLU, arithmetic shift, saturation). The
// activation is then written through a ready-qualified port.
// Optional feature macro: NEURON_LAYER_SEQ_RELU_EN. When it is defined, negative
// neuron results are clamped to zero before the shift.
//
// Write handshake: OUT_WE is valid and holds OUT_ADDR/OUT_DATA stable until
// the cycle where OUT_READY is also high. A write is committed on the rising
// edge that ends that cycle. ABORT masks OUT_WE in the same cycle.
module neuron_layer_sequencer #(
    parameter int OUTPUT_SIZE  = 512,
    parameter int BIAS_WIDTH   = 32,
    parameter int OUT_WIDTH    = 8,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [4:0]            SHIFT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [ADDR_WIDTH-1:0] ROW_ADDR,
    input  logic [BIAS_WIDTH-1:0] NEURON_OUT,
    output logic                  OUT_WE,
    output logic [ADDR_WIDTH-1:0] OUT_ADDR,
    output logic [OUT_WIDTH-1:0]  OUT_DATA,
    input  logic                  OUT_READY,
    output logic [2:0]            DBG_STATE
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(OUTPUT_SIZE - 1);
    localparam logic signed [BIAS_WIDTH-1:0] SAT_HI = BIAS_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [BIAS_WIDTH-1:0] SAT_LO = BIAS_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_WRITE   = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  row_q;
    logic [ADDR_WIDTH-1:0]  row_addr_q;
    logic [ADDR_WIDTH-1:0]  out_addr_q;
    logic [OUT_WIDTH-1:0]   out_data_q;
    logic [4:0]             shift_q;
    logic [CNT_W-1:0]       wait_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   out_we_q;

    logic signed [BIAS_WIDTH-1:0] relu_x;
    logic signed [BIAS_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]         requant_d;

    // Requantise the current datapath result with the shift latched at START.
    always_comb begin
        relu_x = signed'(NEURON_OUT);
`ifdef NEURON_LAYER_SEQ_RELU_EN
        if (relu_x < 0) begin
            relu_x = '0;
        end
`endif
        if (32'(shift_q) >= BIAS_WIDTH) begin
            shifted = {BIAS_WIDTH{relu_x[BIAS_WIDTH-1]}};
        end else begin
            shifted = relu_x >>> shift_q;
        end
        if (shifted > SAT_HI) begin
            requant_d = SAT_HI[OUT_WIDTH-1:0];
        end else if (shifted < SAT_LO) begin
            requant_d = SAT_LO[OUT_WIDTH-1:0];
        end else begin
            requant_d = shifted[OUT_WIDTH-1:0];
        end
    end

    // Layer sequencing FSM with registered outputs; ABORT overrides every non-idle state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            row_addr_q <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            shift_q    <= '0;
            wait_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_we_q   <= 1'b0;
        end else if (ABORT && (state_q != S_IDLE)) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_we_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (START && !ABORT) begin
                        state_q <= S_FETCH;
                        row_q   <= '0;
                        shift_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    row_addr_q <= row_q;
                    wait_q     <= CNT_W'(READ_LATENCY - 1);
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - 1'b1;
                    end else begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    out_data_q <= requant_d;
                    out_addr_q <= row_q;
                    out_we_q   <= 1'b1;
                    state_q    <= S_WRITE;
                end
                S_WRITE: begin
                    if (OUT_READY) begin
                        out_we_q <= 1'b0;
                        if (row_q == LAST_ROW) begin
                            state_q <= S_FINISH;
                        end else begin
                            row_q   <= row_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FINISH: begin
                    // DONE is raised for the single cycle following FINISH; BUSY covers it.
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ROW_ADDR  = row_addr_q;
    assign OUT_ADDR  = out_addr_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_WE    = out_we_q & ~ABORT;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Self-checking bench for neuron_layer_sequencer. Two instances are used: a 4-row layer
// with read latency 1, and a 1-row layer with read latency 3. The datapath is
// modelled either as a plain memory indexed by ROW_ADDR, or as a strict
// timeline that presents the real value only in the cycle before the expected
// sampling edge.
module tb_neuron_layer_sequencer;

    localparam int OS  = 4;
    localparam int RL  = 1;
    localparam int P   = RL + 3;
    localparam int RL3 = 3;
`ifdef NEURON_LAYER_SEQ_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif
    localparam logic [31:0] POISON = 32'h4000_0000;

    // Clock and reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, out_ready;
    logic [4:0]  shift;
    logic        busy, done, out_we;
    logic [1:0]  row_addr, out_addr;
    logic [7:0]  out_data;
    logic [31:0] neuron_out;
    logic [2:0]  dbg_state;

    logic        start3;
    logic [4:0]  shift3;
    logic        busy3, done3, out_we3;
    logic [0:0]  row_addr3, out_addr3;
    logic [7:0]  out_data3;
    logic [31:0] neuron_out3;
    logic [2:0]  dbg_state3;

    neuron_layer_sequencer #(.OUTPUT_SIZE(OS), .BIAS_WIDTH(32), .OUT_WIDTH(8), .READ_LATENCY(RL)) u_dut (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .SHIFT(shift),
        .BUSY(busy), .DONE(done), .ROW_ADDR(row_addr), .NEURON_OUT(neuron_out),
        .OUT_WE(out_we), .OUT_ADDR(out_addr), .OUT_DATA(out_data), .OUT_READY(out_ready),
        .DBG_STATE(dbg_state)
    );

    neuron_layer_sequencer #(.OUTPUT_SIZE(1), .BIAS_WIDTH(32), .OUT_WIDTH(8), .READ_LATENCY(RL3)) u_dut3 (
        .CLK(clk), .RST(rst), .START(start3), .ABORT(1'b0), .SHIFT(shift3),
        .BUSY(busy3), .DONE(done3), .ROW_ADDR(row_addr3), .NEURON_OUT(neuron_out3),
        .OUT_WE(out_we3), .OUT_ADDR(out_addr3), .OUT_DATA(out_data3), .OUT_READY(1'b1),
        .DBG_STATE(dbg_state3)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 1000000;
    int acc_cyc3 = 1000000;
    int mode = 0;
    int nxt, nxt3;
    logic signed [31:0] nv [OS];
    logic signed [31:0] nv3;

    // Datapath model: memory lookup (mode 0) or exact sampling window (mode 1).
    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        if (mode == 0) begin
            neuron_out = nv[row_addr];
        end else begin
            nxt = cyc - acc_cyc + 1 - (RL + 2);
            if (nxt >= 0 && (nxt % P) == 0 && (nxt / P) < OS) neuron_out = nv[nxt / P];
            else neuron_out = POISON;
        end
        nxt3 = cyc - acc_cyc3 + 1 - (RL3 + 2);
        if (nxt3 == 0) neuron_out3 = nv3;
        else neuron_out3 = POISON;
    end

    // Reference requantisation: floor division by 2^sh, then clamp.
    function automatic logic [7:0] ref_q(input logic signed [31:0] x, input int sh);
        longint v, y, d;
        v = x;
        if (RELU && v < 0) v = 0;
        d = longint'(1) << sh;
        if (v >= 0) y = v / d;
        else y = -((-v + d - 1) / d);
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return 8'(y);
    endfunction

    // Scoreboard: expected writes and observed writes
    logic [7:0] exp_q[$];
    int         exp_a_q[$];
    int         exp_t_q[$];
    int         exp_done_r;
    logic [7:0] w_data_q[$];
    int         w_addr_q[$];
    int         w_time_q[$];
    int         done_n, done_r, busy_n, busy_last, we_n, unstable;
    logic       hold_v;
    logic [1:0] hold_a;
    logic [7:0] hold_d;

    // Expected timeline: each row writes RL+2 cycles after the previous commit, delayed by stalls.
    task automatic build_exp(input int nrows, input int sh, input int lo_s, input int lo_len);
        int t, wc;
        exp_q.delete(); exp_a_q.delete(); exp_t_q.delete();
        t = 0;
        for (int k = 0; k < nrows; k++) begin
            wc = t + RL + 2;
            while (wc >= lo_s && wc < lo_s + lo_len) wc++;
            t = wc + 1;
            exp_q.push_back(ref_q(nv[k], sh));
            exp_a_q.push_back(k);
            exp_t_q.push_back(t);
        end
        exp_done_r = t + 1;
    endtask

    // Driver tasks
    task automatic start_layer(input logic [4:0] s);
        @(posedge clk); #1;
        start = 1'b1; shift = s; acc_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0; shift = 5'($urandom_range(0, 31));
    endtask

    task automatic collect(input int ncyc, input int lo_s, input int lo_len,
                           input int abort_at, input int rst_at, input int start_at);
        int r;
        w_data_q.delete(); w_addr_q.delete(); w_time_q.delete();
        done_n = 0; done_r = -1; busy_n = 0; busy_last = -1; we_n = 0; unstable = 0; hold_v = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            r = cyc - acc_cyc;
            out_ready = !(r >= lo_s && r < lo_s + lo_len);
            abort = (r == abort_at);
            rst   = (r == rst_at);
            start = (r == start_at);
            #1;
            if (hold_v && out_we && (out_addr !== hold_a || out_data !== hold_d)) unstable++;
            hold_v = out_we && !out_ready;
            hold_a = out_addr;
            hold_d = out_data;
            if (out_we) we_n++;
            if (out_we && out_ready) begin
                w_data_q.push_back(out_data);
                w_addr_q.push_back(int'(out_addr));
                w_time_q.push_back(r + 1);
            end
            if (done) begin done_n++; done_r = r; end
            if (busy) begin busy_n++; busy_last = r; end
        end
        out_ready = 1'b1; abort = 1'b0; rst = 1'b0; start = 1'b0;
    endtask

    task automatic rand_nv();
        for (int k = 0; k < OS; k++) nv[k] = 32'($urandom_range(0, 1000)) - 32'sd500;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (out_we !== 1'b0) begin errors++; $display("FAIL reset_out_we: got %b expected 0", out_we); end
        checks++; if (row_addr !== 2'd0) begin errors++; $display("FAIL reset_row_addr: got %0d expected 0", row_addr); end
        checks++; if (out_addr !== 2'd0) begin errors++; $display("FAIL reset_out_addr: got %0d expected 0", out_addr); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_layer();
        int sh;
        mode = 1;
        rand_nv();
        sh = $urandom_range(3, 6);
        start_layer(5'(sh));
        collect(22, -100, 0, -1, -1, 8);
        build_exp(OS, sh, -100, 0);
        checks++; if (w_data_q.size() !== OS) begin errors++; $display("FAIL layer_writes: got %0d expected %0d", w_data_q.size(), OS); end
        for (int k = 0; k < OS && k < w_data_q.size(); k++) begin
            checks++; if (w_addr_q[k] !== exp_a_q[k]) begin errors++; $display("FAIL layer_addr[%0d]: got %0d expected %0d", k, w_addr_q[k], exp_a_q[k]); end
            checks++; if (w_data_q[k] !== exp_q[k]) begin errors++; $display("FAIL layer_data[%0d]: got %0d expected %0d", k, $signed(w_data_q[k]), $signed(exp_q[k])); end
            checks++; if (w_time_q[k] !== exp_t_q[k]) begin errors++; $display("FAIL layer_time[%0d]: got %0d expected %0d", k, w_time_q[k], exp_t_q[k]); end
        end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL layer_done_count: got %0d expected 1", done_n); end
        checks++; if (done_r !== OS * (RL + 3) + 1) begin errors++; $display("FAIL layer_done_time: got %0d expected %0d", done_r, OS * (RL + 3) + 1); end
        checks++; if (busy_last !== exp_done_r || busy_n !== busy_last + 1) begin errors++; $display("FAIL layer_busy: got last=%0d n=%0d expected last=%0d n=%0d", busy_last, busy_n, exp_done_r, exp_done_r + 1); end
    endtask

    task automatic test_requant();
        logic [7:0] c [4];
        mode = 0;
        nv[0] = 32'sd1000; nv[1] = 32'sd2000; nv[2] = -32'sd5000; nv[3] = -32'sd500;
        c[0] = 8'd125; c[1] = 8'd127;
        c[2] = RELU ? 8'd0 : 8'h80;
        c[3] = RELU ? 8'd0 : 8'hC1;
        start_layer(5'd3);
        collect(22, -100, 0, -1, -1, -1);
        checks++; if (w_data_q.size() !== 4) begin errors++; $display("FAIL rq_writes: got %0d expected 4", w_data_q.size()); end
        for (int k = 0; k < 4 && k < w_data_q.size(); k++) begin
            checks++; if (w_data_q[k] !== c[k]) begin errors++; $display("FAIL rq_data[%0d]: got %0d expected %0d", k, $signed(w_data_q[k]), $signed(c[k])); end
        end
        nv[0] = -32'sd1; nv[1] = 32'sh7fff_ffff; nv[2] = 32'sh8000_0000; nv[3] = 32'sd5;
        start_layer(5'd31);
        collect(22, -100, 0, -1, -1, -1);
        build_exp(OS, 31, -100, 0);
        checks++; if (w_data_q.size() !== 4) begin errors++; $display("FAIL rq31_writes: got %0d expected 4", w_data_q.size()); end
        for (int k = 0; k < 4 && k < w_data_q.size(); k++) begin
            checks++; if (w_data_q[k] !== exp_q[k]) begin errors++; $display("FAIL rq31_data[%0d]: got %0d expected %0d", k, $signed(w_data_q[k]), $signed(exp_q[k])); end
        end
    endtask

    task automatic test_stall();
        int sh;
        mode = 0;
        rand_nv();
        sh = $urandom_range(3, 6);
        start_layer(5'(sh));
        collect(30, 11, 5, -1, -1, -1);
        build_exp(OS, sh, 11, 5);
        checks++; if (w_data_q.size() !== OS) begin errors++; $display("FAIL stall_writes: got %0d expected %0d", w_data_q.size(), OS); end
        for (int k = 0; k < OS && k < w_data_q.size(); k++) begin
            checks++; if (w_addr_q[k] !== exp_a_q[k] || w_data_q[k] !== exp_q[k] || w_time_q[k] !== exp_t_q[k]) begin
                errors++;
                $display("FAIL stall_write[%0d]: got a=%0d d=%0d t=%0d expected a=%0d d=%0d t=%0d", k,
                         w_addr_q[k], $signed(w_data_q[k]), w_time_q[k], exp_a_q[k], $signed(exp_q[k]), exp_t_q[k]);
            end
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", unstable); end
        checks++; if (we_n !== OS + 5) begin errors++; $display("FAIL stall_we_cycles: got %0d expected %0d", we_n, OS + 5); end
        checks++; if (done_n !== 1 || done_r !== exp_done_r) begin errors++; $display("FAIL stall_done: got n=%0d t=%0d expected n=1 t=%0d", done_n, done_r, exp_done_r); end
    endtask

    task automatic test_abort();
        int sh;
        mode = 1;
        rand_nv();
        start_layer(5'($urandom_range(3, 6)));
        collect(12, -100, 0, 5, -1, -1);
        checks++; if (w_data_q.size() !== 1 || we_n !== 1) begin errors++; $display("FAIL abort_wait_writes: got %0d/%0d expected 1/1", w_data_q.size(), we_n); end
        checks++; if (done_n !== 0) begin errors++; $display("FAIL abort_wait_done: got %0d expected 0", done_n); end
        checks++; if (busy_last !== 5) begin errors++; $display("FAIL abort_wait_busy: got %0d expected 5", busy_last); end
        start_layer(5'($urandom_range(3, 6)));
        collect(8, -100, 0, 3, -1, -1);
        checks++; if (w_data_q.size() !== 0 || we_n !== 0) begin errors++; $display("FAIL abort_write_masked: got %0d/%0d expected 0/0", w_data_q.size(), we_n); end
        checks++; if (done_n !== 0 || busy_last !== 3) begin errors++; $display("FAIL abort_write_state: got done=%0d busy_last=%0d expected 0 3", done_n, busy_last); end
        rand_nv();
        sh = $urandom_range(3, 6);
        start_layer(5'(sh));
        collect(22, -100, 0, -1, -1, -1);
        build_exp(OS, sh, -100, 0);
        checks++; if (w_data_q.size() !== OS) begin errors++; $display("FAIL restart_writes: got %0d expected %0d", w_data_q.size(), OS); end
        for (int k = 0; k < OS && k < w_data_q.size(); k++) begin
            checks++; if (w_addr_q[k] !== exp_a_q[k] || w_data_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL restart_write[%0d]: got a=%0d d=%0d expected a=%0d d=%0d", k,
                         w_addr_q[k], $signed(w_data_q[k]), exp_a_q[k], $signed(exp_q[k]));
            end
        end
        checks++; if (done_n !== 1 || done_r !== exp_done_r) begin errors++; $display("FAIL restart_done: got n=%0d t=%0d expected n=1 t=%0d", done_n, done_r, exp_done_r); end
    endtask

    task automatic test_rst_mid();
        mode = 0;
        rand_nv();
        start_layer(5'($urandom_range(3, 6)));
        collect(24, 15, 100, -1, 16, -1);
        checks++; if (w_data_q.size() !== 3) begin errors++; $display("FAIL rst_writes: got %0d expected 3", w_data_q.size()); end
        checks++; if (done_n !== 0) begin errors++; $display("FAIL rst_done: got %0d expected 0", done_n); end
        checks++; if (busy_last !== 16) begin errors++; $display("FAIL rst_busy_last: got %0d expected 16", busy_last); end
        checks++; if ({busy, done, out_we} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {busy, done, out_we}); end
        checks++; if (row_addr !== 2'd0 || out_addr !== 2'd0 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL rst_values: got row=%0d addr=%0d data=%0d expected 0 0 0", row_addr, out_addr, out_data);
        end
    endtask

    task automatic test_latency3();
        int sh, r, wt, wn, dt, dn;
        logic [7:0] wd;
        nv3 = 32'($urandom_range(0, 1000)) - 32'sd500;
        sh = $urandom_range(3, 6);
        @(posedge clk); #1;
        start3 = 1'b1; shift3 = 5'(sh); acc_cyc3 = cyc + 1;
        @(posedge clk); #1;
        start3 = 1'b0; shift3 = 5'($urandom_range(0, 31));
        wt = -1; wn = 0; dt = -1; dn = 0; wd = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            r = cyc - acc_cyc3;
            if (out_we3) begin wn++; wt = r + 1; wd = out_data3; end
            if (done3) begin dn++; dt = r; end
        end
        checks++; if (wn !== 1 || wt !== RL3 + 3) begin errors++; $display("FAIL lat3_write: got n=%0d t=%0d expected n=1 t=%0d", wn, wt, RL3 + 3); end
        checks++; if (wd !== ref_q(nv3, sh)) begin errors++; $display("FAIL lat3_data: got %0d expected %0d", $signed(wd), $signed(ref_q(nv3, sh))); end
        checks++; if (dn !== 1 || dt !== RL3 + 4) begin errors++; $display("FAIL lat3_done: got n=%0d t=%0d expected n=1 t=%0d", dn, dt, RL3 + 4); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; shift = '0;
        start3 = 1'b0; shift3 = '0; nv3 = '0;
        for (int k = 0; k < OS; k++) nv[k] = '0;
        test_reset();
        test_requant();
        for (int i = 0; i < 3; i++) test_layer();
        test_stall();
        test_abort();
        test_rst_mid();
        test_latency3();
        test_latency3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
